led_blink_ctrl: RTL and testbench
=================================

# led_blink_ctrl

Multi-channel, parametrised LED driver for the FPGA top level, replacing per-signal fixed-rate blink counters. All channels run from one clock. Each channel has a run-time mode (off, on, periodic blink, event-triggered flash), a programmable half-period and a PWM brightness. It sits in the FPGA wrapper beside the SoC and drives board LEDs from heartbeat and event signals.

## Interface
- `NUM_CH`, 4: number of LED channels (1..32).
- `CNT_WIDTH`, 27: width of the per-channel period counter.
- `PWM_WIDTH`, 8: brightness resolution.
- `DEFAULT_PERIOD`, 45000000: `cfg_period` value loaded at reset.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `cfg_valid`  in  1: configuration write request.
- `cfg_ready`  out  1: configuration write accepted when high together with `cfg_valid`.
- `cfg_ch`  in  $clog2(NUM_CH) (min 1): target channel.
- `cfg_mode`  in  2: 0 OFF, 1 ON, 2 BLINK, 3 FLASH.
- `cfg_period`  in  CNT_WIDTH: half-period / flash length minus one, in cycles.
- `cfg_duty`  in  PWM_WIDTH: brightness; all-ones means fully on.
- `evt_i`  in  NUM_CH: per-channel flash trigger, level-sampled each cycle.
- `led_o`  out  NUM_CH: registered LED outputs.
- `tick_o`  out  NUM_CH: one-cycle strobe on a blink toggle or at flash expiry.

## Operation
- Per-channel state: `mode`, `period`, `duty`, `cnt` (CNT_WIDTH), and the logical level `lvl`.
- Reset: `mode`=BLINK, `period`=DEFAULT_PERIOD, `duty`=all-ones, `cnt`=0, `lvl`=0, `led_o`=0, `tick_o`=0, `cfg_ready`=0.
- `cfg_ready` is 1 in every cycle after reset deasserts. A handshake is `cfg_valid & cfg_ready`.
- On a handshake with `cfg_ch < NUM_CH`, the channel loads `mode`, `period` and `duty`, and sets `cnt`=0.
  - BLINK: `lvl`=1.
  - ON: `lvl`=1.
  - OFF: `lvl`=0.
  - FLASH: `lvl`=0.
- On a handshake with `cfg_ch >= NUM_CH`, the write is consumed with no effect.
- OFF: `lvl`=0; `cnt` is held at 0.
- ON: `lvl`=1; `cnt` is held at 0.
- BLINK: `cnt` increments each cycle. When `cnt == period`, `lvl` toggles, `cnt`=0 and `tick` pulses. The half-period is `period+1` cycles; `period`=0 toggles every cycle.
- FLASH, idle (`lvl`=0): `evt_i[ch]`=1 sets `lvl`=1 and `cnt`=0.
- FLASH, active (`lvl`=1):
  - `evt_i[ch]`=1 retriggers (`cnt`=0).
  - Otherwise, when `cnt == period`: `lvl`=0, `cnt`=0 and `tick` pulses.
  - Otherwise `cnt` increments.
- `evt_i` is ignored in all modes other than FLASH.
- PWM: one shared free-running `pwm_cnt` (PWM_WIDTH bits) wraps from 2^PWM_WIDTH−1 to 0.
  - `led_o[ch] = lvl & ((duty == '1) | (pwm_cnt < duty))`.
  - `duty`=0 means always dark.
- Simultaneous handshake and `evt_i` on the same channel: the configuration wins and the event is dropped.
- `cnt` never exceeds `period`, because every configuration write clears it.

## Timing
- A configuration takes effect on the edge that accepts it. `led_o` reflects the new `lvl` one cycle later (the output register).
- `tick_o` is registered and aligned with the `led_o` cycle that shows the transition.
- `evt_i` sampled at edge N gives `led_o` high from cycle N+1 (with duty all-ones). The flash lasts `period+1` cycles after the last trigger.
- After reset release in default BLINK mode, the first rising `led_o` appears DEFAULT_PERIOD+2 cycles after the first active edge.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously), and the configuration returns to defaults.

## Structure
- Package `led_blink_pkg` holds:
  - `led_mode_e` (2-bit enum OFF/ON/BLINK/FLASH);
  - the mode encodings;
  - a `led_cfg_t` struct {mode, period, duty} parametrised via localparam widths.
- Sub-module `led_blink_channel`, instantiated NUM_CH times, owns `mode`/`period`/`duty`/`cnt`/`lvl` and its own `led_o`/`tick_o` registers.
- The top level owns `pwm_cnt`, `cfg_ready`, and the channel-select decode.

## Test plan
- Reset with defaults, except `DEFAULT_PERIOD`=5 (set for this test only) → `led_o`=0 and `tick_o`=0 during reset; first `led_o` rise 7 cycles after the first active edge; toggles every 6 cycles.
- Write ch1 BLINK, period=3, duty=all-ones → `led_o[1]` high 4 / low 4 cycles; `tick_o[1]` pulses every 4 cycles; other channels are undisturbed.
- Write ch2 FLASH, period=9. Pulse `evt_i[2]` once → `led_o[2]` is high for 10 cycles, then `tick_o[2]` pulses. A retrigger at cycle 5 extends the high time to 15 cycles.
- Write ch0 ON, duty=64, PWM_WIDTH=8 → exactly 64 of every 256 cycles are high. duty=0 → always low. duty=255 → always high.
- Write with `cfg_ch`=NUM_CH → handshake completes; no channel changes.
- Write ch2 while `evt_i[2]`=1 in the same cycle → configuration applied, event dropped. Assert `reset` mid-blink → `led_o`=0 within the same cycle; defaults are restored.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared types and encodings for the multi-channel LED blink controller.
package led_blink_pkg;

  localparam logic [1:0] ModeOffEnc   = 2'd0;
  localparam logic [1:0] ModeOnEnc    = 2'd1;
  localparam logic [1:0] ModeBlinkEnc = 2'd2;
  localparam logic [1:0] ModeFlashEnc = 2'd3;

  typedef enum logic [1:0] {
    ModeOff   = ModeOffEnc,
    ModeOn    = ModeOnEnc,
    ModeBlink = ModeBlinkEnc,
    ModeFlash = ModeFlashEnc
  } led_mode_e;

  localparam int unsigned CfgCntWidth = 27;
  localparam int unsigned CfgPwmWidth = 8;

  typedef struct packed {
    led_mode_e              mode;
    logic [CfgCntWidth-1:0] period;
    logic [CfgPwmWidth-1:0] duty;
  } led_cfg_t;

  // Level a channel starts at when it is (re)configured into a mode.
  function automatic logic load_level(led_mode_e mode);
    return (mode == ModeBlink) || (mode == ModeOn);
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: mode/period/duty config, period counter, logical level,
// PWM gating and registered led/tick outputs.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 27,
  parameter int unsigned PWM_WIDTH      = 8,
  parameter int unsigned DEFAULT_PERIOD = 45000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  input  logic                 evt,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 led,
  output logic                 tick
);

  led_mode_e              mode_q, mode_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [PWM_WIDTH-1:0]   duty_q, duty_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   tgl_q, tgl_d;
  logic                   led_q, led_d;
  logic                   tick_q;

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    tgl_d    = 1'b0;
    // A config write takes priority over any same-cycle event.
    if (cfg_we) begin
      mode_d   = led_mode_e'(cfg_mode);
      period_d = cfg_period;
      duty_d   = cfg_duty;
      cnt_d    = '0;
      lvl_d    = load_level(mode_d);
    end else begin
      unique case (mode_q)
        ModeOff: begin
          lvl_d = 1'b0;
          cnt_d = '0;
        end
        ModeOn: begin
          lvl_d = 1'b1;
          cnt_d = '0;
        end
        ModeBlink: begin
          if (cnt_q == period_q) begin
            lvl_d = ~lvl_q;
            cnt_d = '0;
            tgl_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ModeFlash: begin
          if (!lvl_q) begin
            if (evt) begin
              lvl_d = 1'b1;
              cnt_d = '0;
            end
          end else if (evt) begin
            cnt_d = '0;
          end else if (cnt_q == period_q) begin
            lvl_d = 1'b0;
            cnt_d = '0;
            tgl_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led_d = lvl_q & ((duty_q == '1) | (pwm_cnt < duty_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= ModeBlink;
      period_q <= CNT_WIDTH'(DEFAULT_PERIOD);
      duty_q   <= '1;
      cnt_q    <= '0;
      lvl_q    <= 1'b0;
      tgl_q    <= 1'b0;
      led_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      lvl_q    <= lvl_d;
      tgl_q    <= tgl_d;
      led_q    <= led_d;
      // Delayed one stage so the strobe lines up with the led edge it marks.
      tick_q   <= tgl_q;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: shared PWM counter, config handshake and channel
// select decode around NUM_CH independent channel instances.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_WIDTH      = 27,
  parameter int unsigned PWM_WIDTH      = 8,
  parameter int unsigned DEFAULT_PERIOD = 45000000,
  localparam int unsigned CH_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_WIDTH-1:0]  cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  input  logic [NUM_CH-1:0]    evt_i,
  output logic [NUM_CH-1:0]    led_o,
  output logic [NUM_CH-1:0]    tick_o
);

  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic                 cfg_ready_q;
  logic                 cfg_hs;
  logic [NUM_CH-1:0]    cfg_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q   <= '0;
      cfg_ready_q <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_q + PWM_WIDTH'(1);
      cfg_ready_q <= 1'b1;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_hs    = cfg_valid & cfg_ready_q;

  // Out-of-range channel numbers match no instance, so the write is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we[i] = cfg_hs & (cfg_ch == CH_WIDTH'(i));

    led_blink_channel #(
      .CNT_WIDTH      (CNT_WIDTH),
      .PWM_WIDTH      (PWM_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_channel (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we[i]),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .evt        (evt_i[i]),
      .pwm_cnt    (pwm_cnt_q),
      .led        (led_o[i]),
      .tick       (tick_o[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: a 4-channel instance plus a 3-channel
// instance that lets an out-of-range channel number be exercised.
module tb_led_blink_ctrl;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_FLASH = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [26:0] cfg_period;
  logic [7:0]  cfg_duty;
  logic [3:0]  evt;
  logic        ready_a, ready_b;
  logic [3:0]  led_a, tick_a;
  logic [2:0]  led_b, tick_b;

  int checks   = 0;
  int failures = 0;
  int hi;

  always #5 clk = ~clk;

  led_blink_ctrl #(
    .NUM_CH (4), .CNT_WIDTH (27), .PWM_WIDTH (8), .DEFAULT_PERIOD (5)
  ) dut_a (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (ready_a),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .evt_i      (evt),
    .led_o      (led_a),
    .tick_o     (tick_a)
  );

  led_blink_ctrl #(
    .NUM_CH (3), .CNT_WIDTH (27), .PWM_WIDTH (8), .DEFAULT_PERIOD (5)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (ready_b),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .evt_i      (evt[2:0]),
    .led_o      (led_b),
    .tick_o     (tick_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [26:0] period,
                    input logic [7:0] duty);
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = period;
    cfg_duty   = duty;
    cfg_valid  = 1'b1;
    cyc(1);
    cfg_valid  = 1'b0;
  endtask

  task automatic count_high(input int n);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (led_a[0]) hi++;
    end
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0; evt = '0;

    // Reset and default BLINK with period 5
    cyc(2);
    check("rst_led", 32'(led_a), 32'h0);
    check("rst_tick", 32'(tick_a), 32'h0);
    check("rst_ready", 32'(ready_a), 32'h0);
    reset = 1'b0;
    cyc(1);                                     // edge 1
    check("ready_after_rst", 32'(ready_a), 32'h1);
    cyc(5);                                     // edge 6
    check("dflt_e6_led", 32'(led_a), 32'h0);
    cyc(1);                                     // edge 7
    check("dflt_rise_led", 32'(led_a), 32'hF);
    check("dflt_rise_tick", 32'(tick_a), 32'hF);
    check("dflt_rise_led_b", 32'(led_b), 32'h7);
    cyc(5);                                     // edge 12
    check("dflt_e12_led", 32'(led_a), 32'hF);
    check("dflt_e12_tick", 32'(tick_a), 32'h0);
    cyc(1);                                     // edge 13
    check("dflt_fall_led", 32'(led_a), 32'h0);
    check("dflt_fall_tick", 32'(tick_a), 32'hF);

    // ch3 OFF: valid on dut_a, out of range on dut_b
    wr(2'd3, M_OFF, 27'd5, 8'hFF);              // edge 14
    cyc(5);                                     // edge 19
    check("oor_led_a", 32'(led_a), 32'h7);
    check("oor_led_b", 32'(led_b), 32'h7);
    check("oor_tick_a", 32'(tick_a), 32'h7);
    check("oor_ready_b", 32'(ready_b), 32'h1);

    // ch1 BLINK period 3
    wr(2'd1, M_BLINK, 27'd3, 8'hFF);            // edge 20
    cyc(4);                                     // edge 24
    check("b3_e24_led", 32'(led_a), 32'h7);
    check("b3_e24_tick", 32'(tick_a), 32'h0);
    cyc(1);                                     // edge 25
    check("b3_e25_led", 32'(led_a), 32'h0);
    check("b3_e25_tick", 32'(tick_a), 32'h7);
    cyc(3);                                     // edge 28
    check("b3_e28_led", 32'(led_a), 32'h0);
    cyc(1);                                     // edge 29
    check("b3_e29_led", 32'(led_a), 32'h2);
    check("b3_e29_tick", 32'(tick_a), 32'h2);
    cyc(2);                                     // edge 31
    check("b3_e31_led", 32'(led_a), 32'h7);
    check("b3_e31_tick", 32'(tick_a), 32'h5);

    // ch2 FLASH period 9
    wr(2'd2, M_FLASH, 27'd9, 8'hFF);            // edge 32
    cyc(1);                                     // edge 33
    check("fl_idle", 32'(led_a[2]), 32'h0);
    evt = 4'b0100;
    cyc(1);                                     // edge 34
    evt = 4'b0000;
    check("fl_e34", 32'(led_a[2]), 32'h0);
    cyc(1);                                     // edge 35
    check("fl_on", 32'(led_a[2]), 32'h1);
    cyc(9);                                     // edge 44
    check("fl_last_hi", 32'(led_a[2]), 32'h1);
    check("fl_last_tick", 32'(tick_a[2]), 32'h0);
    cyc(1);                                     // edge 45
    check("fl_off", 32'(led_a[2]), 32'h0);
    check("fl_exp_tick", 32'(tick_a[2]), 32'h1);

    // Retrigger five cycles into the flash
    cyc(4);
    evt = 4'b0100;
    cyc(1);                                     // edge 50
    evt = 4'b0000;
    cyc(1);                                     // edge 51
    check("rt_on", 32'(led_a[2]), 32'h1);
    cyc(3);
    evt = 4'b0100;
    cyc(1);                                     // edge 55
    evt = 4'b0000;
    cyc(6);                                     // edge 61
    check("rt_extended", 32'(led_a[2]), 32'h1);
    cyc(4);                                     // edge 65
    check("rt_last_hi", 32'(led_a[2]), 32'h1);
    cyc(1);                                     // edge 66
    check("rt_off", 32'(led_a[2]), 32'h0);
    check("rt_tick", 32'(tick_a[2]), 32'h1);

    // Config and event on the same edge: config wins; OFF ignores events
    evt = 4'b1100;
    wr(2'd2, M_FLASH, 27'd9, 8'hFF);
    evt = 4'b0000;
    cyc(2);
    check("cfg_wins_led", 32'(led_a[2]), 32'h0);
    check("off_ignores_evt", 32'(led_a[3]), 32'h0);

    // PWM on ch0 in ON mode
    wr(2'd0, M_ON, 27'd0, 8'd64);
    count_high(256);
    check("pwm_64", 32'(hi), 32'd64);
    wr(2'd0, M_ON, 27'd0, 8'd1);
    count_high(256);
    check("pwm_1", 32'(hi), 32'd1);
    wr(2'd0, M_ON, 27'd0, 8'd0);
    count_high(256);
    check("pwm_0", 32'(hi), 32'd0);
    wr(2'd0, M_ON, 27'd0, 8'd255);
    count_high(256);
    check("pwm_255", 32'(hi), 32'd256);

    // Asynchronous reset mid-operation
    check("pre_rst_led0", 32'(led_a[0]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_led", 32'(led_a), 32'h0);
    check("async_rst_led_b", 32'(led_b), 32'h0);
    check("async_rst_ready", 32'(ready_a), 32'h0);
    cyc(1);
    reset = 1'b0;
    cyc(6);                                     // edge 6
    check("rerst_e6_led", 32'(led_a), 32'h0);
    cyc(1);                                     // edge 7
    check("rerst_rise_led", 32'(led_a), 32'hF);
    check("rerst_rise_tick", 32'(tick_a), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
